// File: rtl/print_pkg.sv
// Shared constants, state encoding, request record and conversion helpers
// for the print_bcd_writer value-table producer.
package print_pkg;

  localparam logic [7:0]  REC_MAX    = 8'd46;
  localparam int          BIN_W      = 21;
  localparam int          FIFO_DEPTH = 4;
  localparam int          BCD_DIGITS = 7;
  localparam int          VAL_W      = 25;
  localparam logic [20:0] SAT_VAL    = 21'd1999999;
  localparam logic [4:0]  ITER_LAST  = 5'd20;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_CONV  = 2'd2;
  localparam state_t ST_EMIT  = 2'd3;

  typedef struct packed {
    logic [7:0]  rec;
    logic [20:0] bin;
    logic        raw;
  } req_t;

  function automatic logic [20:0] sat_bin(input logic [20:0] bin);
    logic [20:0] res;
    if (bin > SAT_VAL) res = SAT_VAL;
    else               res = bin;
    return res;
  endfunction

  // One double-dabble step; the top digit holds at most 1, so it never needs the add-3.
  function automatic logic [VAL_W-1:0] dd_step(input logic [VAL_W-1:0] bcd, input logic bit_in);
    logic [VAL_W-1:0] t;
    t = bcd;
    for (int i = 0; i < BCD_DIGITS - 1; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      else                     t[4*i +: 4] = t[4*i +: 4];
    end
    return {t[VAL_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/print_bcd_writer_if.sv
// Request and table-write port bundle; master drives requests, slave is the writer.
interface print_bcd_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_rec;
  logic [20:0] req_bin;
  logic        req_raw;
  logic        clear_req;
  logic [7:0]  print_rec;
  logic [24:0] print_val;
  logic        print_set;
  logic        busy;
  logic        err_rec;

  modport master (
    output req_valid, req_rec, req_bin, req_raw, clear_req,
    input  req_ready, print_rec, print_val, print_set, busy, err_rec
  );

  modport slave (
    input  req_valid, req_rec, req_bin, req_raw, clear_req,
    output req_ready, print_rec, print_val, print_set, busy, err_rec
  );
endinterface

// File: rtl/print_req_fifo.sv
// Small synchronous request FIFO with flush; flush wins over a coincident push or pop.
module print_req_fifo
  import print_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = $bits(req_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push & ~o_full  & ~i_flush;
  assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  // Extra MSB on each pointer distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/print_bcd_writer.sv
// Queues print requests, converts binary to packed BCD and writes the value table;
// also runs a zeroing sweep over every record on clear_req.
module print_bcd_writer
  import print_pkg::*;
(
  input  logic                CLOCK_50,
  input  logic                RST,
  print_bcd_writer_if.slave   bus
);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_clr_idx, w_clr_idx_nxt;
  logic              r_clr_pend;
  logic [7:0]        r_rec;
  logic [BIN_W-1:0]  r_bin;
  logic [VAL_W-1:0]  r_bcd;
  logic [4:0]        r_iter;
  logic              r_print_set;
  logic [7:0]        r_print_rec;
  logic [VAL_W-1:0]  r_print_val;
  logic              r_err_rec;

  req_t              w_req_in;
  req_t              w_head;
  logic              w_full, w_empty;
  logic              w_clr_go, w_pop, w_rec_bad;
  logic [VAL_W-1:0]  w_dd_bcd;
  logic              w_set_nxt;
  logic [7:0]        w_rec_nxt;
  logic [VAL_W-1:0]  w_val_nxt;
  logic              w_err_nxt;

  assign w_req_in = '{rec: bus.req_rec, bin: bus.req_bin, raw: bus.req_raw};

  print_req_fifo u_fifo (
    .clk     (CLOCK_50),
    .rst     (RST),
    .i_push  (bus.req_valid),
    .i_din   (w_req_in),
    .i_pop   (w_pop),
    .i_flush (bus.clear_req),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_clr_go  = r_clr_pend | bus.clear_req;
  assign w_pop     = (r_state == ST_IDLE) & ~w_clr_go & ~w_empty;
  assign w_rec_bad = (w_head.rec >= REC_MAX);
  assign w_dd_bcd  = dd_step(r_bcd, r_bin[BIN_W-1]);

  assign bus.req_ready = ~w_full;
  assign bus.busy      = (r_state != ST_IDLE) | ~w_empty | r_clr_pend;
  assign bus.print_set = r_print_set;
  assign bus.print_rec = r_print_rec;
  assign bus.print_val = r_print_val;
  assign bus.err_rec   = r_err_rec;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // A clear arriving in IDLE is taken at once; inside CLEAR it restarts the sweep instead.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_go) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_idx_nxt = 8'd0;
        end else if (w_empty || w_rec_bad) begin
          w_state_nxt = ST_IDLE;
        end else if (w_head.raw) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_state_nxt = ST_CONV;
        end
      end
      ST_CLEAR: begin
        if (bus.clear_req) begin
          w_clr_idx_nxt = 8'd0;
        end else if (r_clr_idx == REC_MAX - 8'd1) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 8'd1;
        end
      end
      ST_CONV: begin
        if (r_iter == ITER_LAST) w_state_nxt = ST_EMIT;
        else                     w_state_nxt = ST_CONV;
      end
      ST_EMIT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output values are computed from the upcoming state so the write strobe is registered.
  always_comb begin
    w_set_nxt = 1'b0;
    w_rec_nxt = r_print_rec;
    w_val_nxt = r_print_val;
    w_err_nxt = w_pop & w_rec_bad;
    case (w_state_nxt)
      ST_CLEAR: begin
        w_set_nxt = 1'b1;
        w_rec_nxt = w_clr_idx_nxt;
        w_val_nxt = '0;
      end
      ST_EMIT: begin
        w_set_nxt = 1'b1;
        if (r_state == ST_IDLE) begin
          w_rec_nxt = w_head.rec;
          w_val_nxt = {4'b0000, w_head.bin};
        end else begin
          w_rec_nxt = r_rec;
          w_val_nxt = w_dd_bcd;
        end
      end
      default: begin
        w_set_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_print_set <= 1'b0;
      r_print_rec <= 8'd0;
      r_print_val <= '0;
      r_err_rec   <= 1'b0;
    end else begin
      r_print_set <= w_set_nxt;
      r_print_rec <= w_rec_nxt;
      r_print_val <= w_val_nxt;
      r_err_rec   <= w_err_nxt;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_clr_pend <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_clr_go) begin
      r_clr_pend <= 1'b0;
    end else if (bus.clear_req && (r_state != ST_CLEAR)) begin
      r_clr_pend <= 1'b1;
    end
  end

  // Converter: shift binary MSB-first into the BCD register, one bit per CONV cycle.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_rec  <= 8'd0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_iter <= 5'd0;
    end else if (w_pop && !w_rec_bad && !w_head.raw) begin
      r_rec  <= w_head.rec;
      r_bin  <= sat_bin(w_head.bin);
      r_bcd  <= '0;
      r_iter <= 5'd0;
    end else if (r_state == ST_CONV) begin
      r_bcd  <= w_dd_bcd;
      r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
      r_iter <= r_iter + 5'd1;
    end
  end

endmodule

// File: tb/tb_print_bcd_writer.sv
// Directed self-checking bench for print_bcd_writer.
module tb_print_bcd_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  print_bcd_writer_if bus();

  print_bcd_writer dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  logic [7:0]  log_rec [$];
  logic [24:0] log_val [$];
  int          log_cyc [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.print_set) begin
      log_rec.push_back(bus.print_rec);
      log_val.push_back(bus.print_val);
      log_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic log_clear();
    log_rec.delete();
    log_val.delete();
    log_cyc.delete();
  endtask

  task automatic send(input logic [7:0] rec, input logic [20:0] bin, input logic raw, output int stall);
    bus.req_valid = 1'b1;
    bus.req_rec   = rec;
    bus.req_bin   = bin;
    bus.req_raw   = raw;
    stall = 0;
    while (!bus.req_ready && stall < 200) begin
      @(negedge clk);
      stall++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int k = 0; k < max_cyc && bus.busy; k++) @(negedge clk);
    chk(tag, bus.busy, 1'b0);
  endtask

  task automatic req_lat(input string tag, input logic [7:0] rec, input logic [20:0] bin,
                         input logic raw, input int exp_lat, input logic [24:0] exp_val);
    int stall;
    int lat;
    send(rec, bin, raw, stall);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.print_set) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rec"}, bus.print_rec, rec);
    chk({tag, "_val"}, bus.print_val, exp_val);
    @(negedge clk);
    chk({tag, "_one"}, bus.print_set, 1'b0);
    chk({tag, "_hold"}, bus.print_val, exp_val);
  endtask

  initial begin
    int stall;
    int seen_err;
    int seen_set;
    int nbad;
    int n0;
    bus.req_valid = 1'b0;
    bus.req_rec   = 8'd0;
    bus.req_bin   = 21'd0;
    bus.req_raw   = 1'b0;
    bus.clear_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_set",   bus.print_set, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_busy",  bus.busy,      1'b0);
    chk("rst_err",   bus.err_rec,   1'b0);
    chk("rst_rec",   bus.print_rec, 8'd0);
    chk("rst_val",   bus.print_val, 25'd0);
    rst = 1'b0;
    @(negedge clk);

    req_lat("bcd",   8'd3,  21'd1234567, 1'b0, 22, 25'h1234567);
    req_lat("sat",   8'd5,  21'd2097151, 1'b0, 22, 25'h1999999);
    req_lat("zero",  8'd5,  21'd0,       1'b0, 22, 25'h0000000);
    req_lat("raw",   8'd7,  21'h0ABCDE,  1'b1, 1,  25'h00ABCDE);

    send(8'd46, 21'd5, 1'b0, stall);
    seen_err = 0;
    seen_set = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.err_rec)   seen_err++;
      if (bus.print_set) seen_set++;
    end
    chk("bad_err", seen_err, 1);
    chk("bad_set", seen_set, 0);
    req_lat("last", 8'd45, 21'd9, 1'b0, 22, 25'h0000009);

    log_clear();
    for (int i = 0; i < 5; i++) send(8'd10 + 8'(i), 21'd10 + 21'(i), 1'b0, stall);
    chk("fill_ready", bus.req_ready, 1'b0);
    send(8'd15, 21'd15, 1'b0, stall);
    chk("fill_stall", (stall > 10), 1'b1);
    wait_idle("fill_idle", 300);
    repeat (2) @(negedge clk);
    chk("fill_cnt", log_rec.size(), 6);
    for (int i = 0; i < 6 && i < log_rec.size(); i++) begin
      chk("fill_rec", log_rec[i], 8'd10 + 8'(i));
      chk("fill_val", log_val[i], 25'h10 + 25'(i));
    end
    if (log_cyc.size() >= 2) chk("fill_gap", log_cyc[1] - log_cyc[0], 23);
    else                     chk("fill_gap", log_cyc.size(), 2);

    log_clear();
    send(8'd20, 21'd123, 1'b0, stall);
    send(8'd21, 21'd1, 1'b0, stall);
    send(8'd22, 21'd2, 1'b0, stall);
    repeat (2) @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    wait_idle("clr_idle", 300);
    repeat (2) @(negedge clk);
    chk("clr_cnt", log_rec.size(), 47);
    if (log_rec.size() >= 1) begin
      chk("clr_fl_rec", log_rec[0], 8'd20);
      chk("clr_fl_val", log_val[0], 25'h0000123);
    end else begin
      chk("clr_fl_rec", log_rec.size(), 1);
    end
    nbad = 0;
    for (int i = 1; i < log_rec.size(); i++) begin
      if (log_rec[i] != 8'(i - 1) || log_val[i] != 25'd0 || log_cyc[i] != log_cyc[1] + i - 1)
        nbad++;
    end
    chk("clr_sweep", nbad, 0);

    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.print_set && bus.print_rec == 8'd10) break;
    end
    chk("abort_at10", bus.print_rec, 8'd10);
    rst = 1'b1;
    #1;
    chk("abort_now", bus.print_set, 1'b0);
    @(negedge clk);
    chk("abort_set", bus.print_set, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    rst = 1'b0;
    n0 = log_rec.size();
    repeat (10) @(negedge clk);
    chk("abort_quiet", log_rec.size() - n0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
